sine_gen: RTL and testbench
===========================

// Module: sine_gen
// PURPOSE
//  Free-running LUT-based sine generator: one 1024-point period of a 16-bit
//  offset-binary sine, plus a second output that is phase-shifted,
//  amplitude-scaled and DC-offset. Top-level signal source for the
//  waveform/DSP experiments; output samples feed scopes or downstream DSP.
// PARAMETERS
//  SIZE        1024      LUT entries per period (power of two)
//  ADDR_W      10        log2(SIZE); index/accumulator width
//  PHASE_STEP  1         index increment per clock (frequency tuning)
//  PHASE_SHIFT 256       index offset of shifted output (256 = +90 deg)
//  AMP_SHIFT   1         right-shift applied to shifted sample (gain 2^-n)
//  DC_OFFSET   17'd32768 constant added to scaled shifted sample
// PORTS
//  clk                in   1   system clock, all logic on rising edge
//  rst_n              in   1   synchronous reset, active low
//  sineOutput         out  16  base sine sample, unsigned offset binary
//  shiftedSineOutput  out  17  phase-shifted, scaled, offset sine, unsigned
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low.
//  - LUT: lut[i] = 32768 + round(32767*sin(2*pi*i/SIZE)), i = 0..SIZE-1.
//    Range 1..65535. Key points: lut[0]=32768, lut[256]=65535,
//    lut[512]=32768, lut[768]=1, lut[1]=32969. Build it as a
//    constant ROM, either a case table or an initial block with
//    synthesizable constants.
//  - State: ADDR_W-bit index idx.
//  - Rising edge with rst_n=0:
//    idx<=0, sineOutput<=0, shiftedSineOutput<=0.
//  - Rising edge with rst_n=1:
//    sineOutput        <= lut[idx]
//    shiftedSineOutput <= (lut[(idx+PHASE_SHIFT) mod SIZE] >> AMP_SHIFT)
//                         + DC_OFFSET   (17-bit, no saturation; max
//                         65535+65535 fits; wrap mod 2^17 otherwise)
//    idx <= (idx + PHASE_STEP) mod SIZE  (natural ADDR_W-bit wrap)
//  - Latency: registered outputs. The sample for idx appears one edge after
//    idx is valid. First edge after reset release outputs lut[0].
//  - Period = SIZE/PHASE_STEP clocks. Wrap 1023->0 is seamless, with no
//    repeated or skipped sample.
//  - Reset asserted mid-period: outputs go to 0 on that edge and restart at
//    lut[0] on the first edge after release.
//  - Both outputs update on the same edge and stay phase-locked.
//    Their relation is fixed by PHASE_SHIFT.
//  - No handshake: a new sample is produced every clock.
// TESTING
//  1 Reset: hold rst_n=0 for 3 edges -> sineOutput=0 and
//    shiftedSineOutput=0.
//  2 Release: edge 1 after release -> sine=32768, shifted=65535
//    (lut[256]>>1=32767, +32768). Edge 2 -> sine=32969.
//  3 Key points: edges 257, 513, 769 after release -> sine=65535, 32768, 1.
//    Edge 769 -> shifted=(lut[0]>>1)+32768=49152.
//  4 Wrap: edge 1025 -> sine=32768 again (idx wrapped). Samples 1024 and
//    1025 match samples 0 and 1, i.e. period exactly 1024.
//  5 Mid-run reset: pulse rst_n=0 at edge 400 -> outputs 0, then the
//    sequence restarts from lut[0].
//  6 Params: PHASE_STEP=4 -> period 256 clocks. AMP_SHIFT=0,
//    DC_OFFSET=0, PHASE_SHIFT=0 -> shifted equals {1'b0, sine} every cycle.

Source files
------------

// File: rtl/sine_gen.sv
// sine_gen: free-running LUT sine generator with a phase-shifted, scaled, offset second output
module sine_gen #(
  parameter int SIZE = 1024,
  parameter int ADDR_W = 10,
  parameter int PHASE_STEP = 1,
  parameter int PHASE_SHIFT = 256,
  parameter int AMP_SHIFT = 1,
  parameter logic [16:0] DC_OFFSET = 17'd32768
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] sineOutput,
  output logic [16:0] shiftedSineOutput
);
  localparam longint SZ = longint'(SIZE);
  localparam longint ONE_Q30 = 64'sd1 << 30;
  localparam longint PI_Q30 = 64'sd3373259426;
  // Elaboration-time sine in Q30 fixed point: fold to the first quadrant, then Taylor series
  function automatic logic [15:0] sin_val(input int i);
    longint a, x, x2, t, s, v;
    logic neg;
    a = longint'(i) % SZ;
    neg = a >= SZ / 64'sd2;
    a = a % (SZ / 64'sd2);
    if (a > SZ / 64'sd4) a = SZ / 64'sd2 - a;
    x = 64'sd2 * PI_Q30 * a / SZ;
    x2 = (x * x) / ONE_Q30;
    t = x;
    s = x;
    for (longint k = 1; k < 12; k++) begin
      t = -((t * x2) / ONE_Q30) / ((64'sd2 * k) * (64'sd2 * k + 64'sd1));
      s = s + t;
    end
    v = (64'sd32767 * s + (ONE_Q30 / 64'sd2)) / ONE_Q30;
    return neg ? 16'(64'sd32768 - v) : 16'(64'sd32768 + v);
  endfunction
  logic [15:0] rom [SIZE];
  for (genvar i = 0; i < SIZE; i++) begin : g_rom
    localparam logic [15:0] V = sin_val(i);
    assign rom[i] = V;
  end
  logic [ADDR_W-1:0] idx, sidx;
  assign sidx = idx + ADDR_W'(PHASE_SHIFT);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      sineOutput <= '0;
      shiftedSineOutput <= '0;
    end else begin
      sineOutput <= rom[idx];
      shiftedSineOutput <= 17'(rom[sidx] >> AMP_SHIFT) + DC_OFFSET;
      idx <= idx + ADDR_W'(PHASE_STEP);
    end
  end
endmodule

// File: tb/tb_sine_gen.sv
// tb_sine_gen: directed checks of sine_gen with default, fast-step and unity-gain instances
module tb_sine_gen;
  logic clk = 0;
  logic rst_n = 0;
  logic [15:0] sine_a, sine_b, sine_c;
  logic [16:0] sh_a, sh_b, sh_c;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sine_gen dut_a (.clk(clk), .rst_n(rst_n), .sineOutput(sine_a), .shiftedSineOutput(sh_a));
  sine_gen #(.PHASE_STEP(4)) dut_b (.clk(clk), .rst_n(rst_n), .sineOutput(sine_b), .shiftedSineOutput(sh_b));
  sine_gen #(.PHASE_SHIFT(0), .AMP_SHIFT(0), .DC_OFFSET(17'd0)) dut_c
    (.clk(clk), .rst_n(rst_n), .sineOutput(sine_c), .shiftedSineOutput(sh_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    n_checks++; if (sine_a !== 16'd0) begin n_fail++; $display("FAIL reset_sine: got %0d expected 0", sine_a); end
    n_checks++; if (sh_a !== 17'd0) begin n_fail++; $display("FAIL reset_shifted: got %0d expected 0", sh_a); end
    n_checks++; if (sine_b !== 16'd0 || sh_c !== 17'd0) begin n_fail++; $display("FAIL reset_others: got %0d/%0d expected 0/0", sine_b, sh_c); end
  endtask

  task automatic test_release();
    rst_n = 1;
    tick();
    n_checks++; if (sine_a !== 16'd32768) begin n_fail++; $display("FAIL edge1_sine: got %0d expected 32768", sine_a); end
    n_checks++; if (sh_a !== 17'd65535) begin n_fail++; $display("FAIL edge1_shifted: got %0d expected 65535", sh_a); end
    tick();
    n_checks++; if (sine_a !== 16'd32969) begin n_fail++; $display("FAIL edge2_sine: got %0d expected 32969", sine_a); end
    n_checks++; if (sh_a !== 17'd65535) begin n_fail++; $display("FAIL edge2_shifted: got %0d expected 65535", sh_a); end
    tick();
    n_checks++; if (sine_a !== 16'd33170) begin n_fail++; $display("FAIL edge3_sine: got %0d expected 33170", sine_a); end
  endtask

  task automatic test_key_points();
    repeat (126) tick();
    n_checks++; if (sine_a !== 16'd55938) begin n_fail++; $display("FAIL edge129_sine: got %0d expected 55938", sine_a); end
    repeat (128) tick();
    n_checks++; if (sine_a !== 16'd65535) begin n_fail++; $display("FAIL edge257_sine: got %0d expected 65535", sine_a); end
    n_checks++; if (sh_a !== 17'd49152) begin n_fail++; $display("FAIL edge257_shifted: got %0d expected 49152", sh_a); end
    repeat (256) tick();
    n_checks++; if (sine_a !== 16'd32768) begin n_fail++; $display("FAIL edge513_sine: got %0d expected 32768", sine_a); end
    n_checks++; if (sh_a !== 17'd32768) begin n_fail++; $display("FAIL edge513_shifted: got %0d expected 32768", sh_a); end
    repeat (256) tick();
    n_checks++; if (sine_a !== 16'd1) begin n_fail++; $display("FAIL edge769_sine: got %0d expected 1", sine_a); end
    n_checks++; if (sh_a !== 17'd49152) begin n_fail++; $display("FAIL edge769_shifted: got %0d expected 49152", sh_a); end
  endtask

  task automatic test_wrap();
    repeat (255) tick();
    n_checks++; if (sine_a !== 16'd32567) begin n_fail++; $display("FAIL edge1024_sine: got %0d expected 32567", sine_a); end
    tick();
    n_checks++; if (sine_a !== 16'd32768) begin n_fail++; $display("FAIL edge1025_sine: got %0d expected 32768", sine_a); end
    n_checks++; if (sh_a !== 17'd65535) begin n_fail++; $display("FAIL edge1025_shifted: got %0d expected 65535", sh_a); end
    tick();
    n_checks++; if (sine_a !== 16'd32969) begin n_fail++; $display("FAIL edge1026_sine: got %0d expected 32969", sine_a); end
  endtask

  task automatic test_mid_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (399) tick();
    rst_n = 0;
    tick();
    n_checks++; if (sine_a !== 16'd0) begin n_fail++; $display("FAIL midreset_sine: got %0d expected 0", sine_a); end
    n_checks++; if (sh_a !== 17'd0) begin n_fail++; $display("FAIL midreset_shifted: got %0d expected 0", sh_a); end
    rst_n = 1;
    tick();
    n_checks++; if (sine_a !== 16'd32768) begin n_fail++; $display("FAIL restart1_sine: got %0d expected 32768", sine_a); end
    n_checks++; if (sh_a !== 17'd65535) begin n_fail++; $display("FAIL restart1_shifted: got %0d expected 65535", sh_a); end
    tick();
    n_checks++; if (sine_a !== 16'd32969) begin n_fail++; $display("FAIL restart2_sine: got %0d expected 32969", sine_a); end
  endtask

  task automatic test_params();
    int bad;
    bad = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int e = 1; e <= 257; e++) begin
      tick();
      if (sh_c !== {1'b0, sine_c}) bad++;
      if (e == 1) begin
        n_checks++; if (sine_b !== 16'd32768) begin n_fail++; $display("FAIL step4_e1: got %0d expected 32768", sine_b); end
        n_checks++; if (sh_c !== 17'd32768) begin n_fail++; $display("FAIL unity_e1: got %0d expected 32768", sh_c); end
      end
      if (e == 2) begin
        n_checks++; if (sine_b !== 16'd33572) begin n_fail++; $display("FAIL step4_e2: got %0d expected 33572", sine_b); end
      end
      if (e == 65) begin
        n_checks++; if (sine_b !== 16'd65535) begin n_fail++; $display("FAIL step4_e65: got %0d expected 65535", sine_b); end
        n_checks++; if (sh_b !== 17'd49152) begin n_fail++; $display("FAIL step4_e65_shifted: got %0d expected 49152", sh_b); end
      end
      if (e == 129) begin
        n_checks++; if (sine_b !== 16'd32768) begin n_fail++; $display("FAIL step4_e129: got %0d expected 32768", sine_b); end
      end
      if (e == 193) begin
        n_checks++; if (sine_b !== 16'd1) begin n_fail++; $display("FAIL step4_e193: got %0d expected 1", sine_b); end
      end
      if (e == 257) begin
        n_checks++; if (sine_b !== 16'd32768) begin n_fail++; $display("FAIL step4_period: got %0d expected 32768", sine_b); end
        n_checks++; if (sh_c !== 17'd65535) begin n_fail++; $display("FAIL unity_e257: got %0d expected 65535", sh_c); end
      end
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL unity_track: got %0d cycles differing expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_key_points();
    test_wrap();
    test_mid_reset();
    test_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
